// File: rtl/user_rq_arb_pkg.sv
// Shared types and limits for the PCIe RQ packet arbiter and its round-robin picker.
package user_rq_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int DEF_DATA_W  = 128;
  localparam int DEF_KEEP_W  = 4;
  localparam int DEF_TUSER_W = 62;
  localparam int MAX_REQ     = 8;

  // Candidate index k steps above base, wrapping modulo n.
  function automatic int rr_idx(int base, int k, int n);
    return (base + k) % n;
  endfunction

endpackage

// File: rtl/user_rq_rr_pick.sv
// Combinational round-robin picker: first requester above last_grant wins, with
// optional strict priority for index 0 (index 0 then leaves the rotating set).
module user_rq_rr_pick
  import user_rq_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int REQ_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [REQ_W-1:0]   last_grant,
  input  logic               prio0_en,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [REQ_W-1:0]   grant_idx,
  output logic               any_req
);

  int cand;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    cand      = 0;
    any_req   = |req;
    if (prio0_en && req[0]) begin
      grant_oh[0] = 1'b1;
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        cand = rr_idx(int'(last_grant), k, NUM_REQ);
        if (grant_oh == '0 && req[cand] && !(prio0_en && cand == 0)) begin
          grant_oh[cand] = 1'b1;
          grant_idx      = REQ_W'(cand);
        end
      end
    end
  end

endmodule

// File: rtl/user_rq_arb.sv
// Packet-level round-robin arbiter sharing the PCIe s_axis_rq port among NUM_REQ requesters.
// Define USER_RQ_ARB_ADMIN_PRIO_EN to give requester 0 (admin) strict priority.
module user_rq_arb
  import user_rq_arb_pkg::*;
#(
  parameter int AXI4_RQ_TUSER_WIDTH = DEF_TUSER_W,
  parameter int C_DATA_WIDTH        = DEF_DATA_W,
  parameter int KEEP_WIDTH          = C_DATA_WIDTH / 32,
  parameter int NUM_REQ             = 2,
  parameter int REQ_W               = $clog2(NUM_REQ)
) (
  input  logic                                   user_clk,
  input  logic                                   user_reset,
  input  logic                                   user_lnk_up,
  input  logic [NUM_REQ*C_DATA_WIDTH-1:0]        req_tdata,
  input  logic [NUM_REQ*KEEP_WIDTH-1:0]          req_tkeep,
  input  logic [NUM_REQ-1:0]                     req_tlast,
  input  logic [NUM_REQ-1:0]                     req_tvalid,
  input  logic [NUM_REQ*AXI4_RQ_TUSER_WIDTH-1:0] req_tuser,
  output logic [NUM_REQ-1:0]                     req_tready,
  output logic [C_DATA_WIDTH-1:0]                m_axis_rq_tdata,
  output logic [KEEP_WIDTH-1:0]                  m_axis_rq_tkeep,
  output logic                                   m_axis_rq_tlast,
  output logic [AXI4_RQ_TUSER_WIDTH-1:0]         m_axis_rq_tuser,
  output logic                                   m_axis_rq_tvalid,
  input  logic                                   m_axis_rq_tready,
  output logic [REQ_W-1:0]                       grant_id,
  output logic                                   busy
);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
    $error("user_rq_arb: NUM_REQ out of range");
  end

`ifdef USER_RQ_ARB_ADMIN_PRIO_EN
  localparam logic PRIO0 = 1'b1;
`else
  localparam logic PRIO0 = 1'b0;
`endif

  arb_state_t                     state, state_nxt;
  logic [REQ_W-1:0]               last_grant;
  logic [NUM_REQ-1:0]             grant_oh;
  logic [NUM_REQ-1:0]             pick_oh;
  logic [REQ_W-1:0]               pick_idx;
  logic                           pick_any;
  logic                           start, done;
  logic [C_DATA_WIDTH-1:0]        sel_tdata;
  logic [KEEP_WIDTH-1:0]          sel_tkeep;
  logic [AXI4_RQ_TUSER_WIDTH-1:0] sel_tuser;
  logic                           sel_tlast, sel_tvalid;

  user_rq_rr_pick #(.NUM_REQ(NUM_REQ), .REQ_W(REQ_W)) u_pick (
    .req        (req_tvalid),
    .last_grant (last_grant),
    .prio0_en   (PRIO0),
    .grant_oh   (pick_oh),
    .grant_idx  (pick_idx),
    .any_req    (pick_any)
  );

  // Slice of the currently granted requester; drives both the data path and tvalid.
  always_comb begin
    sel_tdata  = '0;
    sel_tkeep  = '0;
    sel_tuser  = '0;
    sel_tlast  = 1'b0;
    sel_tvalid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == REQ_W'(i)) begin
        sel_tdata  = req_tdata[i*C_DATA_WIDTH +: C_DATA_WIDTH];
        sel_tkeep  = req_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        sel_tuser  = req_tuser[i*AXI4_RQ_TUSER_WIDTH +: AXI4_RQ_TUSER_WIDTH];
        sel_tlast  = req_tlast[i];
        sel_tvalid = req_tvalid[i];
      end
    end
  end

  assign start = (state == IDLE) && user_lnk_up && pick_any;
  assign done  = (state == BUSY) && sel_tvalid && m_axis_rq_tready && sel_tlast;

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      state      <= IDLE;
      grant_id   <= '0;
      grant_oh   <= '0;
      last_grant <= REQ_W'(NUM_REQ - 1);
    end else begin
      state <= state_nxt;
      if (start) begin
        grant_id <= pick_idx;
        grant_oh <= pick_oh;
      end
      // Admin grants under strict priority leave the rotation untouched.
      if (done && !(PRIO0 && grant_id == '0))
        last_grant <= grant_id;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (done)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Data outputs are forced to zero while reset is held so the port is quiet during reset.
  always_comb begin
    busy             = (state == BUSY);
    m_axis_rq_tvalid = busy && sel_tvalid;
    req_tready       = busy ? (grant_oh & {NUM_REQ{m_axis_rq_tready}}) : '0;
    m_axis_rq_tdata  = user_reset ? '0 : sel_tdata;
    m_axis_rq_tkeep  = user_reset ? '0 : sel_tkeep;
    m_axis_rq_tuser  = user_reset ? '0 : sel_tuser;
    m_axis_rq_tlast  = user_reset ? 1'b0 : sel_tlast;
  end

endmodule

// File: tb/tb_user_rq_arb.sv
// Scoreboard bench for user_rq_arb: beats queued per requester, expected output order
// pushed when stimulus is loaded and popped on each accepted output beat.
module tb_user_rq_arb;
  localparam int N  = 2;
  localparam int DW = 128;
  localparam int KW = 4;
  localparam int UW = 62;
  localparam int RW = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            lnk;
  logic [N*DW-1:0] req_tdata;
  logic [N*KW-1:0] req_tkeep;
  logic [N-1:0]    req_tlast;
  logic [N-1:0]    req_tvalid;
  logic [N*UW-1:0] req_tuser;
  logic [N-1:0]    req_tready;
  logic [DW-1:0]   m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic            m_tlast;
  logic [UW-1:0]   m_tuser;
  logic            m_tvalid;
  logic            m_tready;
  logic [RW-1:0]   grant_id;
  logic            busy;

  always #5 clk = ~clk;

  user_rq_arb dut (
    .user_clk         (clk),
    .user_reset       (rst),
    .user_lnk_up      (lnk),
    .req_tdata        (req_tdata),
    .req_tkeep        (req_tkeep),
    .req_tlast        (req_tlast),
    .req_tvalid       (req_tvalid),
    .req_tuser        (req_tuser),
    .req_tready       (req_tready),
    .m_axis_rq_tdata  (m_tdata),
    .m_axis_rq_tkeep  (m_tkeep),
    .m_axis_rq_tlast  (m_tlast),
    .m_axis_rq_tuser  (m_tuser),
    .m_axis_rq_tvalid (m_tvalid),
    .m_axis_rq_tready (m_tready),
    .grant_id         (grant_id),
    .busy             (busy)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [UW-1:0] user;
    int            src;
  } beat_t;

  beat_t src_q[N][$];
  beat_t pend_q[N][$];
  beat_t exp_q[$];
  int    hold[N];
  logic  bp_mode;
  int    checks = 0;
  int    failures = 0;
  int    acc_cnt = 0;
  logic  prev_last, prev2_last, prev_stall;
  logic [255:0] prev_out;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] pack_beat(beat_t b);
    return {61'b0, b.data, b.keep, b.last, b.user};
  endfunction

  function automatic logic [255:0] out_word();
    return {61'b0, m_tdata, m_tkeep, m_tlast, m_tuser};
  endfunction

  task automatic load(input int src, input int beats);
    beat_t b;
    logic [63:0] u;
    for (int k = 0; k < beats; k++) begin
      b.data = {$urandom, $urandom, $urandom, $urandom};
      b.keep = KW'($urandom_range(1, 15));
      u      = {$urandom, $urandom};
      b.user = u[UW-1:0];
      b.last = (k == beats - 1);
      b.src  = src;
      src_q[src].push_back(b);
      pend_q[src].push_back(b);
    end
  endtask

  task automatic expect_pkt(input int src);
    beat_t b;
    do begin
      b = pend_q[src].pop_front();
      exp_q.push_back(b);
    end while (!b.last);
  endtask

  task automatic drive();
    beat_t b;
    for (int i = 0; i < N; i++) begin
      req_tvalid[i] = (hold[i] == 0) && (src_q[i].size() > 0);
      if (src_q[i].size() > 0) begin
        b = src_q[i][0];
        req_tdata[i*DW +: DW] = b.data;
        req_tkeep[i*KW +: KW] = b.keep;
        req_tuser[i*UW +: UW] = b.user;
        req_tlast[i]          = b.last;
      end
    end
  endtask

  logic [N-1:0] acc;

  // Negedge half: inputs and outputs are settled; judge the handshake due at the next edge.
  task automatic half_a();
    beat_t e;
    int    granted;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    granted = (exp_q.size() > 0) ? exp_q[0].src : -1;
    for (int i = 0; i < N; i++) begin
      acc[i]     = req_tvalid[i] && req_tready[i];
      exp_rdy[i] = busy && (granted == i) && m_tready;
    end
    chk("req_tready", 256'(req_tready), 256'(exp_rdy));
    if (prev_last) chk("bubble_busy", 256'(busy), 256'(0));
    if (prev2_last && exp_q.size() > 0 && lnk) chk("regrant_busy", 256'(busy), 256'(1));
    if (prev_stall) chk("hold_stable", out_word(), prev_out);
    if (m_tvalid && m_tready) begin
      if (exp_q.size() == 0) chk("unexpected_beat", 256'(1), 256'(0));
      else begin
        e = exp_q.pop_front();
        chk("beat_src", 256'(grant_id), 256'(e.src));
        chk("beat_data", out_word(), pack_beat(e));
      end
    end
    prev2_last = prev_last;
    prev_last  = m_tvalid && m_tready && m_tlast;
    prev_stall = m_tvalid && !m_tready;
    prev_out   = out_word();
  endtask

  task automatic half_b();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        void'(src_q[i].pop_front());
        acc_cnt++;
      end
      if (hold[i] > 0) hold[i]--;
    end
    if (bp_mode) m_tready = 1'($urandom_range(0, 1));
    drive();
  endtask

  task automatic step();
    half_a();
    half_b();
  endtask

  task automatic run_until_empty(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", 256'(exp_q.size()), 256'(0));
    m_tready = 1'b1;
    bp_mode  = 1'b0;
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      pend_q[i].delete();
      hold[i] = 0;
    end
    exp_q.delete();
    prev_last  = 1'b0;
    prev2_last = 1'b0;
    prev_stall = 1'b0;
    acc        = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_all();
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Both requesters saturated with npk packets each; order depends on the priority build.
  task automatic contend(input int npk, input int beats);
    for (int k = 0; k < npk; k++) begin
      load(0, beats);
      load(1, beats);
    end
`ifdef USER_RQ_ARB_ADMIN_PRIO_EN
    for (int k = 0; k < npk; k++) expect_pkt(0);
    for (int k = 0; k < npk; k++) expect_pkt(1);
`else
    for (int k = 0; k < npk; k++) begin
      expect_pkt(0);
      expect_pkt(1);
    end
`endif
  endtask

  int base;

  initial begin
    rst      = 1'b1;
    lnk      = 1'b1;
    m_tready = 1'b1;
    bp_mode  = 1'b0;
    clear_all();
    req_tdata  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    req_tkeep  = 8'hff;
    req_tuser  = '1;
    req_tlast  = '1;
    req_tvalid = '1;
    #1;
    // Reset state with live, nonzero inputs.
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_grant", 256'(grant_id), 256'(0));
    chk("rst_tvalid", 256'(m_tvalid), 256'(0));
    chk("rst_tready", 256'(req_tready), 256'(0));
    chk("rst_data", out_word(), 256'(0));
    do_reset();

    // Solo packet on requester 1.
    @(posedge clk); #1;
    load(1, 3);
    expect_pkt(1);
    drive();
    half_a();
    chk("solo_idle", 256'(busy), 256'(0));
    half_b();
    half_a();
    chk("solo_busy", 256'(busy), 256'(1));
    chk("solo_grant", 256'(grant_id), 256'(1));
    half_b();
    run_until_empty(50);
    step();
    chk("solo_idle_after", 256'(busy), 256'(0));

    // Contention: 100 two-beat packets.
    do_reset();
    @(posedge clk); #1;
    contend(50, 2);
    drive();
    run_until_empty(1000);

    // Backpressure with random tready.
    do_reset();
    @(posedge clk); #1;
    bp_mode = 1'b1;
    contend(6, 3);
    drive();
    run_until_empty(2000);

    // Link down in IDLE blocks any grant.
    do_reset();
    @(posedge clk); #1;
    lnk = 1'b0;
    load(0, 2);
    expect_pkt(0);
    drive();
    for (int k = 0; k < 5; k++) begin
      half_a();
      chk("lnk_block", 256'(busy), 256'(0));
      half_b();
    end
    lnk = 1'b1;
    run_until_empty(50);

    // Link drop mid-packet keeps forwarding.
    load(1, 3);
    expect_pkt(1);
    drive();
    base = acc_cnt;
    for (int k = 0; k < 20 && acc_cnt == base; k++) step();
    lnk = 1'b0;
    run_until_empty(50);
    lnk = 1'b1;

    // tvalid gap of 5 cycles mid-packet keeps the grant against a waiting requester.
    load(0, 3);
    load(1, 2);
    expect_pkt(0);
    expect_pkt(1);
    drive();
    base = acc_cnt;
    for (int k = 0; k < 20 && acc_cnt == base; k++) step();
    hold[0] = 5;
    drive();
    for (int k = 0; k < 5; k++) begin
      half_a();
      chk("gap_busy", 256'(busy), 256'(1));
      chk("gap_grant", 256'(grant_id), 256'(0));
      half_b();
    end
    run_until_empty(50);

    // Reset on beat 2 of 4.
    load(1, 4);
    expect_pkt(1);
    drive();
    base = acc_cnt;
    for (int k = 0; k < 20 && acc_cnt == base; k++) step();
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 256'(busy), 256'(0));
    chk("mid_rst_grant", 256'(grant_id), 256'(0));
    chk("mid_rst_tvalid", 256'(m_tvalid), 256'(0));
    chk("mid_rst_tready", 256'(req_tready), 256'(0));
    chk("mid_rst_data", out_word(), 256'(0));
    clear_all();
    drive();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    load(1, 2);
    load(0, 2);
    expect_pkt(0);
    expect_pkt(1);
    drive();
    step();
    half_a();
    chk("post_rst_grant", 256'(grant_id), 256'(0));
    half_b();
    run_until_empty(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/user_rq_arb.md
# user_rq_arb

Packet-level arbiter that shares the single PCIe requester-request (RQ) AXI-Stream port among `NUM_REQ` upstream requesters, for example the admin submission path and the I/O submission queue. It grants one requester at a time, holds the grant until that requester's `tlast` beat is accepted, then re-arbitrates round-robin. It sits between the submission-queue FIFOs and the PCIe IP `s_axis_rq` port, and never interleaves beats of different packets.

## Interface
- `AXI4_RQ_TUSER_WIDTH`, default 62: RQ tuser width.
- `C_DATA_WIDTH`, default 128: RQ tdata width.
- `KEEP_WIDTH`, default `C_DATA_WIDTH/32`: tkeep width.
- `NUM_REQ`, default 2: number of requesters, 2..8. Index 0 is the admin path.
- `REQ_W`, default `$clog2(NUM_REQ)`: grant index width.

Ports:
- `user_clk`  in  1  the single clock.
- `user_reset`  in  1  reset; asynchronous, active-high.
- `user_lnk_up`  in  1  PCIe link up. No new grant is issued while it is low.
- `req_tdata`  in  NUM_REQ*C_DATA_WIDTH  requester tdata, packed; requester i occupies slice i.
- `req_tkeep`  in  NUM_REQ*KEEP_WIDTH  requester tkeep, packed.
- `req_tlast`  in  NUM_REQ  requester tlast.
- `req_tvalid`  in  NUM_REQ  requester tvalid.
- `req_tuser`  in  NUM_REQ*AXI4_RQ_TUSER_WIDTH  requester tuser, packed.
- `req_tready`  out  NUM_REQ  per-requester tready.
- `m_axis_rq_tdata` / `_tkeep` / `_tlast` / `_tuser`  out  C_DATA_WIDTH / KEEP_WIDTH / 1 / AXI4_RQ_TUSER_WIDTH  to the PCIe IP.
- `m_axis_rq_tvalid`  out  1  to the PCIe IP.
- `m_axis_rq_tready`  in  1  from the PCIe IP.
- `grant_id`  out  REQ_W  current or last grant index (status).
- `busy`  out  1  high while in state BUSY.

## Operation
- Two-state FSM: IDLE and BUSY.
- IDLE → BUSY:
  - Condition: `user_lnk_up` is high and any `req_tvalid` is high.
  - The winner is the first requester with tvalid high, searching upward from `(last_grant+1) mod NUM_REQ` with wrap.
  - The winner is registered into `grant_id`.
- In BUSY the output is a combinational mux of the granted requester:
  - `m_axis_rq_tdata`/`tkeep`/`tlast`/`tuser` equal the granted slice.
  - `m_axis_rq_tvalid` = `req_tvalid[grant_id]`.
  - `req_tready[grant_id]` = `m_axis_rq_tready`.
  - All other `req_tready` bits are 0.
- BUSY → IDLE: on a beat where `m_axis_rq_tvalid && m_axis_rq_tready && m_axis_rq_tlast`. `last_grant` updates to `grant_id` on that same edge.
- In IDLE:
  - All `req_tready` are 0 and `m_axis_rq_tvalid` is 0.
  - The data outputs mirror the `grant_id` slice; they are don't-care while tvalid is 0.
- Link drop mid-packet (`user_lnk_up` falls while BUSY): the grant is held and forwarding continues. The packet is not truncated; the PCIe IP deasserts tready if needed.
- A requester that deasserts tvalid mid-packet keeps the grant. The arbiter waits indefinitely.
- A single-beat packet (tlast on the first beat) is legal.

## Timing
- Reset values:
  - state = IDLE, `grant_id` = 0, `last_grant` = `NUM_REQ-1` (so requester 0 wins first), `busy` = 0.
  - All `req_tready` = 0, `m_axis_rq_tvalid` = 0, data outputs = 0.
- Arbitration latency:
  - A request seen in IDLE at edge N gives a grant at N+1. The first beat can transfer in cycle N+1.
  - Exactly one bubble cycle (IDLE) follows every packet.
- Data path through BUSY: zero latency, no registers.
- Simultaneous requests: resolved by the round-robin pointer only. A requester that is not granted gets no tready.
- Reset asserted mid-packet: the FSM returns to IDLE immediately and the partial packet is dropped. Clearing the upstream queues on the same reset is the system's responsibility.

## Configuration
- `USER_RQ_ARB_ADMIN_PRIO_EN`:
  - Defined: requester 0 has strict priority. If `req_tvalid[0]` is high in IDLE, requester 0 wins regardless of the pointer, and the pointer is not updated by requester-0 grants. Requesters 1..NUM_REQ-1 share round-robin.
  - Undefined: pure round-robin over all requesters.

## Structure
- Package `user_rq_arb_pkg` holds:
  - the state enum (IDLE, BUSY);
  - default width constants (128, 4, 62);
  - the `MAX_REQ` = 8 limit.
- Sub-module `user_rq_rr_pick`: combinational round-robin picker.
  - Inputs: request vector, `last_grant`, optional priority-0 enable.
  - Outputs: one-hot winner, winner index, any-request flag.
  - Reused by other arbiters.

## Test plan
- **Solo packet:** requester 1 sends 3 beats with tlast on beat 3 and `m_axis_rq_tready`=1. Required: `grant_id`=1 one cycle after tvalid; 3 output beats bit-exact; then `busy`=0 for exactly 1 cycle.
- **Contention:** both requesters continuously send 2-beat packets. Required: grants alternate 0,1,0,1; no beat interleaving; no packet lost over 100 packets.
- **Backpressure:** `m_axis_rq_tready` toggles at random in BUSY. Required: `req_tready` equals `m_axis_rq_tready` for the granted requester only; data is held stable while tvalid is high and tready is low.
- **Link and valid gaps:** `user_lnk_up`=0 in IDLE blocks any grant. `user_lnk_up` dropping mid-packet keeps forwarding. A requester tvalid gap of 5 cycles mid-packet keeps the grant.
- **Reset mid-packet:** assert `user_reset` on beat 2 of 4. Required: all outputs reach their reset values immediately; after release requester 0 wins first.
- **`USER_RQ_ARB_ADMIN_PRIO_EN` defined:** requesters 0 and 1 both saturate. Required: requester 0 wins every arbitration; requester 1 is granted only in cycles where `req_tvalid[0]`=0.
